stack_controller: RTL
=====================

Name: stack_controller

Overview:
- Sequencer directly upstream of `memory`. It turns push/pop/clear commands from the calculator core into `memory` mode/address/data_in cycles and captures `memory.data_out`.
- Owns the stack pointer and keeps a cached top-of-stack register. Flags overflow and underflow.
- Provides a valid/ready command handshake so the core stalls while a memory access is in flight.

Parameters:
- ADDR_BITS, `MEMORY_ADDR_BITS: memory address width; stack capacity is DEPTH = 2**ADDR_BITS.
- DATA_W, 4: cell width; must match `memory` (fixed at 4).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd  in  2  00 NOP, 01 PUSH, 10 POP, 11 CLEAR.
- cmd_data  in  4  push operand.
- cmd_ready  out  1  high when a command can be accepted.
- pop_valid  out  1  one-cycle pulse carrying a popped value.
- pop_data  out  4  popped value, valid with pop_valid.
- top  out  4  current top-of-stack; 0 when empty.
- depth  out  ADDR_BITS+1  number of stacked entries, 0..DEPTH.
- empty  out  1  depth==0.
- full  out  1  depth==DEPTH.
- err_overflow  out  1  one-cycle pulse: PUSH rejected because full.
- err_underflow  out  1  one-cycle pulse: POP rejected because empty.
- mem_mode  out  2  drives memory.mode.
- mem_addr  out  ADDR_BITS  drives memory.address.
- mem_wdata  out  4  drives memory.data_in.
- mem_rdata  in  4  from memory.data_out.

Behaviour:
- Handshake: a command is accepted on a rising edge when cmd_valid && cmd_ready. A NOP is accepted and ignored.
- States: INIT, IDLE, WRITE, READ, CAPTURE, CLEAR. cmd_ready=1 only in IDLE.
- Reset (rst_n low, asynchronous): state=INIT, depth=0, top=0, mem_mode=NONE, mem_addr=0, mem_wdata=0. All pulses and cmd_ready are 0. This applies mid-operation as well; any in-flight command is dropped.
- INIT: the first cycle after reset release drives mem_mode=CLEAR (wipes cells), then -> IDLE.
- PUSH, not full: -> WRITE, registering the write data.
  - WRITE cycle: mem_mode=WRITE, mem_addr=depth (old), mem_wdata=cmd_data.
  - End of WRITE: top=cmd_data, depth+1, -> IDLE.
  - Accept-to-ready latency is 2 cycles.
- PUSH when full: stay IDLE, err_overflow pulses the next cycle, depth/top/memory unchanged.
- POP, not empty: the cycle after accept, pop_valid=1 and pop_data=old top; depth-1.
  - If new depth==0: top=0, -> IDLE (latency 1).
  - Else -> READ: mem_mode=READ, mem_addr=new depth-1.
  - Then CAPTURE: mem_mode=READ held, top<=mem_rdata, -> IDLE (latency 3).
- POP when empty: err_underflow pulse, no other change.
- CLEAR: -> CLEAR state, one cycle mem_mode=CLEAR; depth=0, top=0, -> IDLE (latency 2). CLEAR is legal when already empty and sets no error flag.
- mem_mode=NONE in every state/cycle not listed above. mem_addr/mem_wdata hold their last values when idle.
- depth arithmetic is ADDR_BITS+1 wide, so DEPTH is representable; mem_addr never wraps because guarded ops are rejected.
- empty, full and top are registered and consistent with depth in the same cycle.
- cmd_data is sampled only at acceptance.

Decomposition:
- Shared constants.v (already guarded by `CONSTANTS) holds:
  - `MEMORY_ADDR_BITS
  - `MEMORY_MODE_NONE/WRITE/READ/CLEAR
  - new STACK_CMD_NOP/PUSH/POP/CLEAR encodings
  - state encodings (3 bits)
- The FSM and datapath fit in one module.
- A small sub-module `stack_pointer` (depth register with inc/dec/clear, full/empty compare) is natural and reusable.

Test Plan (ADDR_BITS=2, DEPTH=4, memory model attached):
- Reset release -> exactly one CLEAR cycle on mem_mode, then cmd_ready=1, depth=0, empty=1, top=0.
- PUSH 3,7,A,F -> each is a WRITE to addr 0..3 with matching data; final depth=4, full=1, top=F. A 5th PUSH 2 -> err_overflow pulse, memory untouched.
- From full, POP x4 -> pop_data F,A,7,3; top after each is A,7,3,0; READ addrs 2,1,0, with the last pop doing no READ. A 5th POP -> err_underflow, no pop_valid.
- PUSH 5, PUSH 9, CLEAR -> one CLEAR cycle, depth=0, top=0. Then POP -> err_underflow.
- Back-to-back cmd_valid held high with PUSH 1,2 -> second accepted exactly 2 cycles after first; no command is lost or duplicated.
- rst_n low during a POP's READ state -> outputs immediately at reset values. After release, the INIT CLEAR occurs and a later PUSH 4 yields top=4, depth=1.

Source files
------------

// File: rtl/stack_controller_pkg.sv
// Shared types and constants for the stack controller and its memory interface.
package stack_controller_pkg;

    localparam int unsigned MEMORY_ADDR_BITS = 4;
    localparam int unsigned DATA_W           = 4;

    typedef logic [DATA_W-1:0] cell_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_WRITE = 2'b01,
        MEM_READ  = 2'b10,
        MEM_CLEAR = 2'b11
    } mem_mode_e;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_PUSH  = 2'b01,
        CMD_POP   = 2'b10,
        CMD_CLEAR = 2'b11
    } stack_cmd_e;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_READ    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_CLEAR   = 3'd5
    } state_e;

    typedef struct packed {
        stack_cmd_e op;
        cell_t      data;
    } cmd_t;

    // Memory mode driven while the controller sits in a given state.
    function automatic mem_mode_e state_mem_mode(state_e s);
        mem_mode_e m;
        m = MEM_NONE;
        case (s)
            ST_WRITE:            m = MEM_WRITE;
            ST_READ, ST_CAPTURE: m = MEM_READ;
            ST_CLEAR:            m = MEM_CLEAR;
            default:             m = MEM_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Command handshake, status and memory-side signals of the stack controller.
interface stack_controller_if
    import stack_controller_pkg::*;
#(
    parameter int unsigned ADDR_BITS = MEMORY_ADDR_BITS
) ();

    logic                 cmd_valid;
    stack_cmd_e           cmd;
    cell_t                cmd_data;
    logic                 cmd_ready;
    logic                 pop_valid;
    cell_t                pop_data;
    cell_t                top;
    logic [ADDR_BITS:0]   depth;
    logic                 empty;
    logic                 full;
    logic                 err_overflow;
    logic                 err_underflow;
    mem_mode_e            mem_mode;
    logic [ADDR_BITS-1:0] mem_addr;
    cell_t                mem_wdata;
    cell_t                mem_rdata;

    modport slave (
        input  cmd_valid, cmd, cmd_data, mem_rdata,
        output cmd_ready, pop_valid, pop_data, top, depth, empty, full,
               err_overflow, err_underflow, mem_mode, mem_addr, mem_wdata
    );

    modport master (
        output cmd_valid, cmd, cmd_data, mem_rdata,
        input  cmd_ready, pop_valid, pop_data, top, depth, empty, full,
               err_overflow, err_underflow, mem_mode, mem_addr, mem_wdata
    );

endinterface

// File: rtl/stack_controller_stack_pointer.sv
// Stack depth register with increment/decrement/clear and registered full/empty flags.
module stack_pointer #(
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               clr_i,
    output logic [ADDR_BITS:0] depth_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned        DEPTH_W   = ADDR_BITS + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(1) << ADDR_BITS;

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               empty_q, full_q;

    always_comb begin
        depth_d = depth_q;
        if (clr_i) begin
            depth_d = '0;
        end else if (inc_i) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec_i) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    // Flags derive from the next depth so they line up with depth_q every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            depth_q <= depth_d;
            empty_q <= (depth_d == '0);
            full_q  <= (depth_d == DEPTH_MAX);
        end
    end

    assign depth_o = depth_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/stack_controller.sv
// Push/pop/clear sequencer in front of the stack memory with a cached top-of-stack.
module stack_controller
    import stack_controller_pkg::*;
#(
    parameter int unsigned ADDR_BITS = MEMORY_ADDR_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_controller_if.slave bus
);

    localparam int unsigned DEPTH_W = ADDR_BITS + 1;

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 pop_valid_q, pop_valid_d;
    cell_t                pop_data_q, pop_data_d;
    cell_t                top_q, top_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_unf_q, err_unf_d;
    mem_mode_e            mem_mode_q, mem_mode_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    cell_t                mem_wdata_q, mem_wdata_d;

    cmd_t                 cmd_c;
    logic                 accept_c;
    logic                 sp_inc_c, sp_dec_c, sp_clr_c;
    logic [DEPTH_W-1:0]   depth_w;
    logic                 empty_w, full_w;

    stack_pointer #(.ADDR_BITS(ADDR_BITS)) u_stack_pointer (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (sp_inc_c),
        .dec_i   (sp_dec_c),
        .clr_i   (sp_clr_c),
        .depth_o (depth_w),
        .empty_o (empty_w),
        .full_o  (full_w)
    );

    assign cmd_c    = '{op: bus.cmd, data: bus.cmd_data};
    assign accept_c = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cmd_ready_q <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            top_q       <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            mem_mode_q  <= MEM_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            top_q       <= top_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            mem_mode_q  <= mem_mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state; INIT wipes memory through the CLEAR state before going idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_CLEAR;
            ST_IDLE: begin
                if (accept_c) begin
                    case (cmd_c.op)
                        CMD_PUSH:  if (!full_w) state_d = ST_WRITE;
                        CMD_POP:   if (!empty_w && (depth_w != DEPTH_W'(1))) state_d = ST_READ;
                        CMD_CLEAR: state_d = ST_CLEAR;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE:   state_d = ST_IDLE;
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            ST_CLEAR:   state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // Output/datapath next values; registered alongside the state so they match it.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        mem_mode_d  = state_mem_mode(state_d);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        top_d       = top_q;
        err_ovf_d   = 1'b0;
        err_unf_d   = 1'b0;
        sp_inc_c    = 1'b0;
        sp_dec_c    = 1'b0;
        sp_clr_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    case (cmd_c.op)
                        CMD_PUSH: begin
                            if (full_w) begin
                                err_ovf_d = 1'b1;
                            end else begin
                                mem_addr_d  = ADDR_BITS'(depth_w);
                                mem_wdata_d = cmd_c.data;
                            end
                        end
                        CMD_POP: begin
                            if (empty_w) begin
                                err_unf_d = 1'b1;
                            end else begin
                                pop_valid_d = 1'b1;
                                pop_data_d  = top_q;
                                sp_dec_c    = 1'b1;
                                if (depth_w == DEPTH_W'(1)) begin
                                    top_d = '0;
                                end else begin
                                    mem_addr_d = ADDR_BITS'(depth_w - DEPTH_W'(2));
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE: begin
                top_d    = mem_wdata_q;
                sp_inc_c = 1'b1;
            end
            ST_CAPTURE: top_d = bus.mem_rdata;
            ST_CLEAR: begin
                top_d    = '0;
                sp_clr_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.pop_valid     = pop_valid_q;
    assign bus.pop_data      = pop_data_q;
    assign bus.top           = top_q;
    assign bus.depth         = depth_w;
    assign bus.empty         = empty_w;
    assign bus.full          = full_w;
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
    assign bus.mem_mode      = mem_mode_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;

endmodule
